// File: rtl/xbar_bridge_pkg.sv
// Shared types and helpers for the XBAR bridge response tracker.
// Destination vectors are one-hot; FIFO entries hold the binary slave index.
package xbar_bridge_pkg;

  localparam int N_SLAVE_DEF         = 16;
  localparam int DATA_WIDTH_DEF      = 32;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int IDX_W               = $clog2(N_SLAVE_DEF);

  typedef logic [N_SLAVE_DEF-1:0] dest_vec_t;
  typedef logic [IDX_W-1:0]       dest_idx_t;

  function automatic logic is_onehot(input dest_vec_t v);
    return (v != '0) && ((v & (v - dest_vec_t'(1))) == '0);
  endfunction

  // OR-reduction encoder; only meaningful when v is one-hot.
  function automatic dest_idx_t onehot2idx(input dest_vec_t v);
    dest_idx_t idx;
    idx = '0;
    for (int i = 0; i < N_SLAVE_DEF; i++)
      if (v[i]) idx = idx | dest_idx_t'(i);
    return idx;
  endfunction

endpackage

// File: rtl/bridge_dest_fifo.sv
// In-order FIFO of outstanding destination indices. The occupancy count is
// kept separately from the pointers so full and empty never alias.
module bridge_dest_fifo
  import xbar_bridge_pkg::*;
#(
  parameter int DEPTH     = MAX_OUTSTANDING_DEF,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  dest_idx_t            din_i,
  output dest_idx_t            dout_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  dest_idx_t                mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]     count_q;
  logic                     do_push, do_pop;

  assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    end
  end

endmodule

// File: rtl/xbar_bridge_resp_tracker.sv
// Response path of the XBAR bridge: tracks granted requests in order and
// forwards the head slave's read response to the master one cycle later.
module xbar_bridge_resp_tracker
  import xbar_bridge_pkg::*;
#(
  parameter int N_SLAVE         = N_SLAVE_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_fire_i,
  input  logic [N_SLAVE-1:0]            destination_i,
  input  logic [N_SLAVE-1:0]            slave_r_valid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0] slave_r_rdata_i,
  input  logic [N_SLAVE-1:0]            slave_r_opc_i,
  output logic                          r_valid_o,
  output logic [DATA_WIDTH-1:0]         r_rdata_o,
  output logic                          r_opc_o,
  output logic                          stall_o,
  output logic [CNT_WIDTH-1:0]          outstanding_o,
  output logic                          err_o,
  output logic                          err_sticky_o
);

  dest_idx_t             head;
  logic [CNT_WIDTH-1:0]  count, count_d;
  logic                  full, empty;
  logic                  dest_ok, push, match;
  logic [N_SLAVE-1:0]    head_vec;
  logic                  err_d, stall_d;

  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic                  r_opc_q;
  logic                  stall_q, err_q, err_sticky_q;

  assign dest_ok = is_onehot(destination_i);
  assign push    = req_fire_i & dest_ok & ~full;
  assign match   = ~empty & slave_r_valid_i[head];

  bridge_dest_fifo #(
    .DEPTH     (MAX_OUTSTANDING),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (match),
    .din_i   (onehot2idx(destination_i)),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Only the head slave may respond; with nothing outstanding every valid is stray.
  always_comb begin
    head_vec = '0;
    if (!empty) head_vec[head] = 1'b1;
  end

  assign err_d = (req_fire_i & ~dest_ok)
               | (req_fire_i & dest_ok & full)
               | (|(slave_r_valid_i & ~head_vec));

  // Stall tracks the count the FIFO will hold after this edge.
  assign count_d = count + CNT_WIDTH'(push) - CNT_WIDTH'(match);
  assign stall_d = (count_d == CNT_WIDTH'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q    <= 1'b0;
      r_rdata_q    <= '0;
      r_opc_q      <= 1'b0;
      stall_q      <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      r_valid_q <= match;
      if (match) begin
        r_rdata_q <= slave_r_rdata_i[int'(head)*DATA_WIDTH +: DATA_WIDTH];
        r_opc_q   <= slave_r_opc_i[head];
      end
      stall_q      <= stall_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_q | err_d;
    end
  end

  assign r_valid_o     = r_valid_q;
  assign r_rdata_o     = r_rdata_q;
  assign r_opc_o       = r_opc_q;
  assign stall_o       = stall_q;
  assign outstanding_o = count;
  assign err_o         = err_q;
  assign err_sticky_o  = err_sticky_q;

endmodule

// File: tb/tb_xbar_bridge_resp_tracker.sv
// Directed bench for the bridge response tracker; inputs change #1 after the
// rising edge and outputs are checked at that same point.
module tb_xbar_bridge_resp_tracker;

  localparam int NS = 16;
  localparam int DW = 32;
  localparam int CW = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_fire;
  logic [NS-1:0]      dest;
  logic [NS-1:0]      s_valid;
  logic [NS*DW-1:0]   s_rdata;
  logic [NS-1:0]      s_opc;
  logic               r_valid;
  logic [DW-1:0]      r_rdata;
  logic               r_opc;
  logic               stall;
  logic [CW-1:0]      outstanding;
  logic               err;
  logic               err_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xbar_bridge_resp_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .req_fire_i      (req_fire),
    .destination_i   (dest),
    .slave_r_valid_i (s_valid),
    .slave_r_rdata_i (s_rdata),
    .slave_r_opc_i   (s_opc),
    .r_valid_o       (r_valid),
    .r_rdata_o       (r_rdata),
    .r_opc_o         (r_opc),
    .stall_o         (stall),
    .outstanding_o   (outstanding),
    .err_o           (err),
    .err_sticky_o    (err_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_fire = 1'b0;
    dest     = '0;
    s_valid  = '0;
    s_opc    = '0;
  endtask

  task automatic fire(input logic [NS-1:0] d);
    req_fire = 1'b1;
    dest     = d;
  endtask

  task automatic resp(input int k, input logic [DW-1:0] data, input logic opc);
    s_valid[k]           = 1'b1;
    s_opc[k]             = opc;
    s_rdata[k*DW +: DW]  = data;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    s_rdata = '0;
    do_reset();
    chk("rst_valid", r_valid, 0);
    chk("rst_rdata", r_rdata, 0);
    chk("rst_opc", r_opc, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_sticky", err_sticky, 0);

    // 1: single transaction to slave 3
    fire(16'h0008); step(); idle();
    chk("t1_cnt1", outstanding, 1);
    step();
    resp(3, 32'hDEADBEEF, 1'b0); step(); idle();
    chk("t1_valid", r_valid, 1);
    chk("t1_data", r_rdata, 32'hDEADBEEF);
    chk("t1_cnt0", outstanding, 0);
    chk("t1_err", err, 0);
    step();
    chk("t1_valid_lo", r_valid, 0);
    chk("t1_data_hold", r_rdata, 32'hDEADBEEF);
    chk("t1_sticky", err_sticky, 0);

    // 2: fill to MAX, overflow, drain in order
    fire(16'h0001); step();
    fire(16'h0020); step();
    fire(16'h0020); step();
    chk("t2_nostall3", stall, 0);
    fire(16'h8000); step();
    chk("t2_cnt4", outstanding, 4);
    chk("t2_stall", stall, 1);
    fire(16'h0002); step(); idle();
    chk("t2_ovf_err", err, 1);
    chk("t2_ovf_cnt", outstanding, 4);
    step();
    chk("t2_err_pulse", err, 0);
    resp(0, 32'h000000A0, 1'b0); step(); idle();
    chk("t2_v0", r_valid, 1);
    chk("t2_d0", r_rdata, 32'hA0);
    chk("t2_stall_drop", stall, 0);
    resp(5, 32'h000000A5, 1'b0); step(); idle();
    chk("t2_d1", r_rdata, 32'hA5);
    resp(5, 32'h000000B5, 1'b0); step(); idle();
    chk("t2_v2", r_valid, 1);
    chk("t2_d2", r_rdata, 32'hB5);
    resp(15, 32'h000000AF, 1'b1); step(); idle();
    chk("t2_d3", r_rdata, 32'hAF);
    chk("t2_opc3", r_opc, 1);
    chk("t2_cnt0", outstanding, 0);
    chk("t2_noerr", err, 0);
    chk("t2_sticky", err_sticky, 1);

    // 3: out-of-order response is rejected
    fire(16'h0004); step();
    fire(16'h0080); step(); idle();
    resp(7, 32'h77, 1'b0); step(); idle();
    chk("t3_err", err, 1);
    chk("t3_novalid", r_valid, 0);
    chk("t3_cnt", outstanding, 2);
    resp(2, 32'h22, 1'b0); step(); idle();
    chk("t3_v2", r_valid, 1);
    chk("t3_d2", r_rdata, 32'h22);
    chk("t3_err_lo", err, 0);
    chk("t3_cnt1", outstanding, 1);
    resp(7, 32'h77, 1'b0); step(); idle();
    chk("t3_d7", r_rdata, 32'h77);
    chk("t3_cnt0", outstanding, 0);

    // 4: steady push+pop at count 2 across pointer wrap
    fire(16'h0001); step();
    fire(16'h0002); step(); idle();
    for (int i = 0; i < 10; i++) begin
      fire(16'h1 << ((i + 2) % 16));
      resp(i % 16, 32'h100 + i, i[0]);
      step(); idle();
      chk("t4_v", r_valid, 1);
      chk("t4_d", r_rdata, 32'h100 + i);
      chk("t4_opc", r_opc, i[0]);
      chk("t4_cnt", outstanding, 2);
      chk("t4_err", err, 0);
    end
    resp(10, 32'h10A, 1'b0); step(); idle();
    chk("t4_dA", r_rdata, 32'h10A);
    resp(11, 32'h10B, 1'b0); step(); idle();
    chk("t4_dB", r_rdata, 32'h10B);
    chk("t4_cnt0", outstanding, 0);

    // 5: bad destinations, then push+response while empty
    do_reset();
    chk("t5_sticky_clr", err_sticky, 0);
    fire(16'h0000); step(); idle();
    chk("t5_zero_err", err, 1);
    chk("t5_zero_cnt", outstanding, 0);
    fire(16'h0011); step(); idle();
    chk("t5_multi_err", err, 1);
    chk("t5_multi_cnt", outstanding, 0);
    step();
    chk("t5_err_lo", err, 0);
    chk("t5_sticky", err_sticky, 1);
    fire(16'h0040); resp(6, 32'h66, 1'b0); step(); idle();
    chk("t5_same_err", err, 1);
    chk("t5_same_nov", r_valid, 0);
    chk("t5_same_cnt", outstanding, 1);
    resp(6, 32'h67, 1'b0); step(); idle();
    chk("t5_late_v", r_valid, 1);
    chk("t5_late_d", r_rdata, 32'h67);

    // 6: reset with entries in flight
    fire(16'h0002); step();
    fire(16'h0004); step();
    fire(16'h0010); step(); idle();
    chk("t6_cnt3", outstanding, 3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_cnt", outstanding, 0);
    chk("t6_valid", r_valid, 0);
    chk("t6_rdata", r_rdata, 0);
    chk("t6_stall", stall, 0);
    chk("t6_err", err, 0);
    chk("t6_sticky", err_sticky, 0);
    resp(1, 32'h11, 1'b0); step(); idle();
    chk("t6_late_err", err, 1);
    chk("t6_late_nov", r_valid, 0);
    chk("t6_late_sticky", err_sticky, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
